// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream input and instruction memory write bus of program_loader
interface program_loader_if #(
   parameter int data_bits           = 32,
   parameter int memory_address_bits = 10
);
   logic [7:0]                     in_data;
   logic                           in_valid;
   logic                           in_ready;
   logic                           mem_write;
   logic [memory_address_bits-1:0] mem_address;
   logic [data_bits-1:0]           mem_write_data;

   // loader view: consumes the byte stream, produces memory writes
   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_write, mem_address, mem_write_data
   );

   // upstream view: produces the byte stream, observes memory writes
   modport master (
      output in_data, in_valid,
      input  in_ready, mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: byte frame to 32-bit instruction memory writes with XOR check
module program_loader #(
   parameter int data_bits           = 32,
   parameter int memory_size         = 1024,
   parameter int memory_address_bits = $clog2(memory_size)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   program_loader_if.slave  bus,
   output logic             core_reset,
   output logic             busy,
   output logic             done,
   output logic             error
);
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;

   // memory_size is limited to 65535, so it always fits the 16-bit length field
   localparam logic [15:0] max_words = 16'(memory_size);

   state_t        state;
   state_t        state_nxt;
   logic [15:0]   len;
   logic [15:0]   word_cnt;
   logic [1:0]    byte_idx;
   logic [7:0]    checksum;
   logic [23:0]   word_buf;
   logic          accept;
   logic [15:0]   len_in;
   logic          last_word;

   assign accept    = bus.in_valid && bus.in_ready;
   assign len_in    = {bus.in_data, len[7:0]};
   assign last_word = (word_cnt + 16'd1) == len;

   // next state, so that the status outputs can be registered in step with the state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERROR: if (start) state_nxt = LEN_LO;
         LEN_LO:            if (accept) state_nxt = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if (len_in == 16'd0)          state_nxt = CHECK;
               else if (len_in > max_words)  state_nxt = ERROR;
               else                          state_nxt = DATA;
            end
         end
         DATA:   if (accept && byte_idx == 2'd3 && last_word) state_nxt = CHECK;
         CHECK:  if (accept) state_nxt = (bus.in_data == checksum) ? DONE : ERROR;
         default: state_nxt = IDLE;
      endcase
   end

   // state register, word assembly, memory write strobe and registered status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         len                <= '0;
         word_cnt           <= '0;
         byte_idx           <= '0;
         checksum           <= '0;
         word_buf           <= '0;
         bus.in_ready       <= 1'b0;
         bus.mem_write      <= 1'b0;
         bus.mem_address    <= '0;
         bus.mem_write_data <= '0;
         core_reset         <= 1'b1;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
      end else begin
         state        <= state_nxt;
         bus.in_ready <= state_nxt inside {LEN_LO, LEN_HI, DATA, CHECK};
         busy         <= state_nxt inside {LEN_LO, LEN_HI, DATA, CHECK};
         done         <= state_nxt == DONE;
         error        <= state_nxt == ERROR;
         core_reset   <= state_nxt != DONE;
         bus.mem_write <= 1'b0;

         // a new load starts from word 0 with a fresh checksum
         if ((state inside {IDLE, DONE, ERROR}) && start) begin
            word_cnt <= '0;
            byte_idx <= '0;
            checksum <= '0;
         end

         if (accept) begin
            case (state)
               LEN_LO: len[7:0] <= bus.in_data;
               LEN_HI: len      <= len_in;
               DATA: begin
                  checksum <= checksum ^ bus.in_data;
                  byte_idx <= byte_idx + 2'd1;
                  // little-endian: earlier bytes shift down toward bits [7:0]
                  word_buf <= {bus.in_data, word_buf[23:8]};
                  if (byte_idx == 2'd3) begin
                     bus.mem_write      <= 1'b1;
                     bus.mem_address    <= word_cnt[memory_address_bits-1:0];
                     bus.mem_write_data <= data_bits'({bus.in_data, word_buf});
                     word_cnt           <= word_cnt + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
